// File: rtl/tick_if.sv
// ---------------------------------------------------------------------------
// tick_if : control/status bundle of the tick generator.
//   master : the game FSM side. It drives the controls and reads the status.
//   slave  : the tick generator itself.
// Signals
//   start, stop, period_load : one-cycle command pulses
//   enable                   : level, 1 = count, 0 = pause while running
//   one_shot                 : sampled when a start is accepted
//   period_in [WIDTH]        : period in cycles, latched by period_load
//   tick                     : one-cycle pulse on each period expiry
//   running                  : high while the countdown is active
//   load_err                 : one-cycle pulse when a zero period is loaded
//   tick_count [CNT_W]       : wrapping tally of ticks since reset
// ---------------------------------------------------------------------------
interface tick_if #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             enable;
  logic             one_shot;
  logic [WIDTH-1:0] period_in;
  logic             period_load;
  logic             tick;
  logic             running;
  logic             load_err;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output start, stop, enable, one_shot, period_in, period_load,
    input  tick, running, load_err, tick_count
  );

  modport slave (
    input  start, stop, enable, one_shot, period_in, period_load,
    output tick, running, load_err, tick_count
  );
endinterface

// File: rtl/tick_generator.sv
// ---------------------------------------------------------------------------
// tick_generator : programmable tick source for game timing.
//   A loadable period is counted down. Each expiry produces a registered
//   one-cycle tick, and the wrapping tally is bumped. The generator runs
//   either continuously or one-shot, and it can be paused with enable.
// Ports
//   clock : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : tick_if.slave control/status bundle
// ---------------------------------------------------------------------------
module tick_generator #(
  parameter int unsigned WIDTH          = 28,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic  clock,
  input  logic  reset,
  tick_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q;
  logic             os_q, os_d;
  logic             expire;
  logic             tick_q;
  logic             running_q;
  logic             load_err_q;
  logic [CNT_W-1:0] tick_count_q;

  // Next-state logic. Priority is stop, then start, then the countdown, so
  // a start or stop in the same cycle as count==0 suppresses the tick.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    count_d = count_q;
    os_d    = os_q;
    expire  = 1'b0;

    if (bus.stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (bus.start) begin
      // Restart uses the period held before any same-cycle period_load.
      state_d = RUN;
      count_d = period_q - ONE;
      os_d    = bus.one_shot;
    end else if (state_q == RUN && bus.enable) begin
      if (count_q == '0) begin
        expire = 1'b1;
        if (os_q) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = period_q - ONE;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period_q     <= DEF_PERIOD;
      os_q         <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      load_err_q   <= 1'b0;
      tick_count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments. Every register
      // then samples values from before the edge, whatever the statement order.
      state_q    <= state_d;
      count_q    <= count_d;
      os_q       <= os_d;
      tick_q     <= expire;
      running_q  <= (state_d == RUN);
      load_err_q <= bus.period_load && (bus.period_in == '0);
      // A zero period would make the countdown meaningless, so it is refused.
      if (bus.period_load && bus.period_in != '0) begin
        period_q <= bus.period_in;
      end
      if (expire) begin
        tick_count_q <= tick_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.tick       = tick_q;
  assign bus.running    = running_q;
  assign bus.load_err   = load_err_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_tick_generator : directed and random checks of tick_generator. The
// checks run against a model that counts enabled cycles up from each start
// or reload until they equal the period in force.
// ---------------------------------------------------------------------------
module tb_tick_generator;
  localparam int unsigned WIDTH = 28;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned DEFP  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  tick_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tick_generator #(
    .WIDTH(WIDTH),
    .DEFAULT_PERIOD(DEFP),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_run;
  int m_elapsed;   // enabled cycles since the last start/reload
  int m_cur_p;     // period in force for the current countdown
  bit m_os;
  int m_period;    // period that the next start/reload will use
  int m_cnt;       // tick tally, modulo 2^CNT_W
  bit m_tick;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("tick", 32'(bus.tick), 32'(m_tick));
    check("running", 32'(bus.running), 32'(m_run));
    check("load_err", 32'(bus.load_err), 32'(m_err));
    check("tick_count", 32'(bus.tick_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_run = 0; m_elapsed = 0; m_cur_p = 0; m_os = 0;
    m_period = DEFP; m_cnt = 0; m_tick = 0; m_err = 0;
  endtask

  // One clock: drive the inputs, take the edge, advance the model, compare.
  task automatic step(input bit st, input bit sp, input bit en, input bit os,
                      input bit ld, input int pin);
    bus.start       = st;
    bus.stop        = sp;
    bus.enable      = en;
    bus.one_shot    = os;
    bus.period_load = ld;
    bus.period_in   = WIDTH'(pin);
    @(posedge clock);
    m_tick = 0;
    m_err  = ld && (pin == 0);
    if (sp) begin
      m_run = 0;
    end else if (st) begin
      m_run = 1; m_elapsed = 0; m_cur_p = m_period; m_os = os;
    end else if (m_run && en) begin
      m_elapsed++;
      if (m_elapsed == m_cur_p) begin
        m_tick    = 1;
        m_cnt     = (m_cnt + 1) % (1 << CNT_W);
        m_elapsed = 0;
        m_cur_p   = m_period;
        if (m_os) m_run = 0;
      end
    end
    if (ld && pin != 0) m_period = pin;
    #1;
    check_all();
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, 0, en, 0, 0, 0);
  endtask

  // Reset is applied between clock edges. The outputs must clear before any edge arrives.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.enable = 0; bus.one_shot = 0;
    bus.period_load = 0; bus.period_in = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;

    // 1: continuous, ticks at 5, 10, 15
    step(1, 0, 1, 0, 0, 0);
    run(15, 1);
    check("t1_tally", 32'(bus.tick_count), 32'd3);

    // 2: one-shot, single tick then idle
    do_reset();
    step(1, 0, 1, 1, 0, 0);
    run(12, 1);

    // 3: pause for 3 cycles mid-period, ticks at 8, 13, 18
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    run(2, 1);
    run(3, 0);
    run(15, 1);

    // 4: load 3 mid-run, then a zero load is refused
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 3);
    run(12, 1);
    step(0, 0, 1, 0, 1, 0);
    run(7, 1);
    check("t4_period", 32'(m_period), 32'd3);

    // 5: start+stop together, then stop exactly at count==0
    do_reset();
    step(1, 1, 1, 0, 0, 0);
    run(6, 1);
    step(1, 0, 1, 0, 0, 0);
    run(4, 1);
    step(0, 1, 1, 0, 0, 0);
    run(6, 1);
    check("t5_tally", 32'(bus.tick_count), 32'd0);

    // 6: tally wraps at 2 bits, then reset while tick is high
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    run(25, 1);
    check("t6_wrap", 32'(bus.tick_count), 32'd1);
    step(1, 0, 1, 0, 0, 0);
    run(5, 1);
    check("t6_tick_hi", 32'(bus.tick), 32'd1);
    do_reset();

    // Random phase with sparse commands, short periods and occasional zero loads
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 14) == 0), int'($urandom_range(0, 6)));
      if (i == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
